// File: rtl/bitwise_serial_unit_pkg.sv
// Shared encodings for the bit-serial bitwise unit.
// Op codes and FSM state type.
package bitwise_serial_unit_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_serial_unit_lane.sv
// One LANE-wide slice of the bitwise operation.
// Purely combinational.
module bitwise_lane
  import bitwise_serial_unit_pkg::*;
#(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic [2:0]      op,
  output logic [LANE-1:0] y
);

  always_comb begin
    y = a;
    unique case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/bitwise_serial_unit.sv
// Bitwise op unit, LANE bits per cycle, LSB slice first.
// Valid/ready on both sides; one op in flight.
module bitwise_serial_unit
  import bitwise_serial_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int NSLICE = WIDTH / LANE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % LANE != 0) begin : g_bad_lane
    $error("WIDTH must be a multiple of LANE");
  end

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;
  logic [2:0]       op_q;
  logic [LANE-1:0]  sl_a;
  logic [LANE-1:0]  sl_b;
  logic [LANE-1:0]  sl_y;
  logic             last;
  int               idx;

  assign idx  = int'(cnt) * LANE;
  assign last = (cnt == LAST);
  assign sl_a = a_q[idx +: LANE];
  assign sl_b = b_q[idx +: LANE];

  bitwise_lane #(.LANE(LANE)) u_lane (
    .a  (sl_a),
    .b  (sl_b),
    .op (op_q),
    .y  (sl_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (in_valid)  state_nx = ST_BUSY;
      ST_BUSY: if (last)      state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // Operands are snapshotted so later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      res  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q  <= in_a;
            b_q  <= in_b;
            op_q <= op;
            cnt  <= '0;
          end
        end
        ST_BUSY: begin
          res[idx +: LANE] <= sl_y;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out       = res;

endmodule

// File: tb/tb_bitwise_serial_unit.sv
// Directed bench for bitwise_serial_unit.
// Three configurations, scoreboard queues per instance.
module tb_bitwise_serial_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [15:0] a0, b0, out0;
  logic [2:0]  op0s;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [15:0] a1, b1, out1;
  logic [2:0]  op1s;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [31:0] a2, b2, out2;
  logic [2:0]  op2s;

  logic [31:0] sb0[$];
  logic [31:0] sb1[$];
  logic [31:0] sb2[$];

  bitwise_serial_unit #(.WIDTH(16), .LANE(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(a0), .in_b(b0), .op(op0s),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out(out0), .busy(busy0)
  );

  bitwise_serial_unit #(.WIDTH(16), .LANE(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(a1), .in_b(b1), .op(op1s),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out(out1), .busy(busy1)
  );

  bitwise_serial_unit #(.WIDTH(32), .LANE(8)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(a2), .in_b(b2), .op(op2s),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out(out2), .busy(busy2)
  );

  function automatic logic [31:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input int w);
    logic [31:0] r;
    logic [31:0] m;
    case (o)
      3'd0:    r = ~a;
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = a ^ b;
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~(a ^ b);
      default: r = a;
    endcase
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return r & m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run0(input logic [2:0] o, input logic [15:0] a,
                      input logic [15:0] b, input logic ordy,
                      input int hold, input string tag);
    int lat;
    logic rdy_bad;
    logic stab_bad;
    logic [15:0] held;
    logic [31:0] exp;
    chk({tag, "_in_ready"}, 32'(in_ready0), 32'd1);
    in_valid0 = 1'b1;
    op0s = o;
    a0 = a;
    b0 = b;
    out_ready0 = ordy;
    sb0.push_back(model(o, 32'(a), 32'(b), 16));
    @(negedge clk);
    in_valid0 = 1'b0;
    lat = 0;
    rdy_bad = 1'b0;
    while (!out_valid0 && lat < 20) begin
      if (in_ready0 || !busy0) rdy_bad = 1'b1;
      a0 = ~a0;
      b0 = b0 + 16'd1;
      op0s = op0s + 3'd1;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_busy_no_ready"}, 32'(rdy_bad), 32'd0);
    held = out0;
    stab_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid0 = 1'b1;
      a0 = 16'($urandom);
      b0 = 16'($urandom);
      op0s = 3'($urandom);
      @(negedge clk);
      if (!out_valid0 || in_ready0 || out0 !== held) stab_bad = 1'b1;
    end
    in_valid0 = 1'b0;
    if (hold > 0) chk({tag, "_hold_stable"}, 32'(stab_bad), 32'd0);
    out_ready0 = 1'b1;
    exp = (sb0.size() > 0) ? sb0.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_out"}, 32'(out0), exp);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid0), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready0), 32'd1);
    out_ready0 = 1'b0;
  endtask

  task automatic run1(input logic [2:0] o, input logic [15:0] a,
                      input logic [15:0] b, input string tag);
    int lat;
    logic [31:0] exp;
    in_valid1 = 1'b1;
    op1s = o;
    a1 = a;
    b1 = b;
    out_ready1 = 1'b1;
    sb1.push_back(model(o, 32'(a), 32'(b), 16));
    @(negedge clk);
    in_valid1 = 1'b0;
    a1 = ~a1;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd1);
    exp = (sb1.size() > 0) ? sb1.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_out"}, 32'(out1), exp);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid1), 32'd0);
  endtask

  task automatic run2(input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input string tag);
    int lat;
    logic [31:0] exp;
    in_valid2 = 1'b1;
    op2s = o;
    a2 = a;
    b2 = b;
    out_ready2 = 1'b1;
    sb2.push_back(model(o, a, b, 32));
    @(negedge clk);
    in_valid2 = 1'b0;
    a2 = ~a2;
    b2 = 32'h0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    exp = (sb2.size() > 0) ? sb2.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_out"}, out2, exp);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid2), 32'd0);
  endtask

  initial begin
    in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; b0 = '0; op0s = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; op1s = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; op2s = '0;
    #1;
    chk("rst_out", 32'(out0), 32'd0);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run0(3'd0, 16'h00FF, 16'h0000, 1'b0, 0, "not");
    run0(3'd1, 16'hF0F0, 16'h3C3C, 1'b1, 0, "and");
    run0(3'd3, 16'hFFFF, 16'h1234, 1'b1, 0, "xor");
    run0(3'd2, 16'h0F00, 16'h00F0, 1'b0, 5, "or");

    in_valid0 = 1'b1;
    op0s = 3'd5;
    a0 = 16'h0000;
    b0 = 16'h0000;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    chk("nor_mid_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid0), 32'd0);
    chk("abort_in_ready", 32'(in_ready0), 32'd1);
    chk("abort_out", 32'(out0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_valid", 32'(out_valid0), 32'd0);

    run0(3'd7, 16'hBEEF, 16'h1111, 1'b1, 0, "pass");

    run1(3'd4, 16'hAAAA, 16'hFFFF, "nand_l16");

    run2(3'd6, 32'h1234_5678, 32'h1234_5678, "xnor_w32");
    run2(3'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, "and_w32");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bitwise_serial_unit.md
Name: bitwise_serial_unit

Overview:
Parametrised, multi-operation successor to the fixed 16-bit inverter. It applies a selectable bitwise operation (NOT/AND/OR/XOR/NAND/NOR/XNOR/PASS) to WIDTH-bit operands. Processing is LANE bits per cycle, LSB slice first, to trade latency for gate count. The block sits between ALU-side producers and consumers, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width in bits
LANE, 4, bits processed per cycle; WIDTH % LANE must be 0, else elaboration error
NSLICE (localparam), WIDTH/LANE, slices per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept (IDLE only)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored for NOT/PASS)
op  input  3  0 NOT a, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS a
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out  output  WIDTH  result register
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, slice counter=0, result reg=0, latched a/b/op=0, out_valid=0, busy=0, in_ready=1.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge, latch in_a, in_b and op, clear counter and go BUSY. The result register is not cleared on accept.
- BUSY: each edge computes slice k = bits [k*LANE +: LANE] from the latched operands/op, writes it into the result reg and increments the counter. On the edge processing k=NSLICE-1, counter wraps to 0 and state goes to DONE.
- Inputs are ignored during BUSY/DONE; changes to in_a/in_b/op after accept have no effect.
- DONE: out_valid=1 and out=result, both held stable until out_valid&&out_ready at an edge, then IDLE. The result reg keeps its value; only out_valid drops.
- Latency: out_valid rises NSLICE cycles after the accept edge (4 cycles for 16/4). No same-cycle accept in DONE, so throughput is one op per NSLICE+2 cycles minimum.
- LANE==WIDTH: a single BUSY cycle; behaviour is otherwise identical.
- out_ready held high before DONE is harmless; the handshake only completes while out_valid=1.
- Reset mid-BUSY or mid-DONE aborts the operation immediately. All reset values apply and no partial result is ever flagged valid.

Decomposition:
- Shared package: op encoding localparams (OP_NOT..OP_PASS, 3-bit), FSM state encoding (IDLE/BUSY/DONE, 2-bit).
- One natural sub-module: bitwise_lane, a combinational LANE-wide op slice (a, b, op -> y), instantiated once and muxed by the slice counter.

Test Plan:
- WIDTH=16, LANE=4: NOT in_a=0x00FF -> out=0xFF00, out_valid 4 cycles after accept, in_ready=0 throughout.
- AND 0xF0F0, 0x3C3C -> 0x3030; then XOR 0xFFFF, 0x1234 -> 0xEDCB. Covers back-to-back ops with out_ready=1, in_ready returning high the cycle after the result handshake.
- out_ready low for 5 cycles in DONE: out_valid and out (OR 0x0F00, 0x00F0 -> 0x0FF0) held stable; in_a toggling during BUSY/DONE does not alter the result.
- rst_n pulsed low during the second BUSY cycle of NOR 0x0000, 0x0000: out_valid=0, in_ready=1, out=0 immediately. A subsequent PASS 0xBEEF -> 0xBEEF.
- WIDTH=16, LANE=16: NAND 0xAAAA, 0xFFFF -> 0x5555 with out_valid 1 cycle after accept.
- WIDTH=32, LANE=8: XNOR 0x12345678, 0x12345678 -> 0xFFFFFFFF after 4 cycles; counter wraps to 0 correctly.
